aes_round_engine: RTL
=====================

# aes_round_engine

Iterative AES encryption datapath, directly downstream of `aes_key_mem`. It drives the round index to the key memory and consumes the returned 128-bit round key. It shares the key memory's S-box through the `sboxw`/`new_sboxw` word port and transforms one 128-bit plaintext block into ciphertext for 128-bit and 256-bit keys.

## Interface
- No parameters.
- `clk`  in  1  – system clock; all state changes on the rising edge.
- `reset_n`  in  1  – reset; asynchronous and active-low.
- `next`  in  1  – start request; accepted only in a cycle where `ready`=1.
- `keylen`  in  1  – key length: 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds). Sampled at accept.
- `round`  out  4  – round index presented to `aes_key_mem`.
- `round_key`  in  128  – key for `round`; combinational from the key memory in the same cycle.
- `sboxw`  out  32  – word sent to the S-box.
- `new_sboxw`  in  32  – S-box result for `sboxw`; combinational in the same cycle.
- `block`  in  128  – plaintext; sampled at accept only.
- `new_block`  out  128  – state register; ciphertext is valid while `ready`=1 after a completed run.
- `ready`  out  1  – 1 = idle and result valid; 0 = busy.

## Operation
- Byte order follows FIPS-197: state byte 0 = bits [127:120]; columns are 32-bit words, word 0 = [127:96].
- State machine IDLE → SBOX → MAIN → (SBOX | IDLE).
- **IDLE**
  - `ready`=1 and `round`=0.
  - On `next`=1: state ← `block` ^ `round_key` (round 0).
  - Latch `keylen` to fix final_round (10 or 14).
  - round_ctr ← 1, word_ctr ← 0, go to SBOX.
- **SBOX** (4 cycles)
  - `sboxw` = state word[word_ctr].
  - State word[word_ctr] ← `new_sboxw`, then word_ctr increments.
  - After word 3, go to MAIN. word_ctr wraps to 0.
- **MAIN** (1 cycle)
  - state ← AddRoundKey(MixColumns(ShiftRows(state)), `round_key`).
  - MixColumns is skipped when round_ctr == final_round.
  - MixColumns uses GF(2^8) with polynomial 0x11B.
  - If round_ctr == final_round, go to IDLE. Otherwise round_ctr increments and the FSM returns to SBOX.
- `round` = round_ctr in SBOX and MAIN, and 0 in IDLE.
- `sboxw` = state word[word_ctr] in all states.
- `next` while busy is ignored. It is neither queued nor does it restart the run.
- The block does not observe the key memory's `ready`. The integrator must not assert `next` until the key memory reports ready.
- `keylen` changes while busy have no effect.

## Timing
- Reset values:
  - FSM = IDLE, `ready`=1.
  - `new_block`=0.
  - `round`=0.
  - round_ctr=0, word_ctr=0.
  - `sboxw`=0.
- Reset asserted mid-run aborts the run immediately and restores the reset values. No partial result survives.
- Accept edge = E0. Round r completes at edge E(5r).
- `ready` returns to 1 after E50 (AES-128) or E70 (AES-256).
- The ciphertext is stable on `new_block` from that cycle until the next accept.
- `ready` falls in the cycle after E0.
- Back-to-back operation: `next` may be asserted in the first cycle `ready`=1, giving a throughput of 51 cycles per block (AES-128).
- `new_block` tracks intermediate state while busy. Consumers must qualify it with `ready`.
- The combinational path is `round` → key memory → `round_key` → state register, all within one cycle.

## Test plan
- **FIPS-197 App. B**
  - Stimulus: keylen=0, key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734.
  - Response: `new_block`=3925841d02dc09fbdc118597196a0b32, `ready` rises exactly 50 edges after accept.
  - Bench instantiates `aes_key_mem` and shares the S-box.
- **FIPS-197 C.1**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff.
  - Response: 69c4e0d86a7b0430d8cdb78070b4c55a.
- **FIPS-197 C.3**
  - Stimulus: keylen=1, key 000102…1f, same block as C.1.
  - Response: 8ea2b7ca516745bfeafc49904b496089, `ready` after 70 edges.
- **Busy ignore**
  - Stimulus: pulse `next` with a different `block` at E20 of a C.1 run.
  - Response: result is still 69c4e0d8…, and `ready` stays 0 until E50.
- **Reset mid-run**
  - Stimulus: drop `reset_n` at E23, release, then rerun C.1.
  - Response: `ready`=1 and `new_block`=0 during reset, and the rerun gives the correct ciphertext.
- **Back-to-back**
  - Stimulus: C.1 followed immediately by App. B, with `next` in the first ready cycle.
  - Response: both ciphertexts are correct and the second is ready 50 edges after the second accept.

Source files
------------

// File: rtl/aes_round_engine.sv
// Iterative AES encryption round engine. It shares the S-box word port with aes_key_mem
// and takes round keys from it.
module aes_round_engine (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {StIdle, StSbox, StMain} state_e;

    state_e       state_q;
    logic [127:0] block_q;
    logic [3:0]   round_ctr_q;
    logic [1:0]   word_ctr_q;
    logic         keylen_q;
    logic         ready_q;

    logic [3:0]   final_round;
    logic         last_round;
    logic [127:0] sbox_state;
    logic [127:0] shifted;
    logic [127:0] main_state;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Byte (row r, column c) sits at index 4c+r; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign final_round = keylen_q ? 4'd14 : 4'd10;
    assign last_round  = (round_ctr_q == final_round);

    always_comb begin
        sbox_state = block_q;
        sboxw      = block_q[127:96];
        unique case (word_ctr_q)
            2'd0: begin
                sboxw               = block_q[127:96];
                sbox_state[127:96]  = new_sboxw;
            end
            2'd1: begin
                sboxw               = block_q[95:64];
                sbox_state[95:64]   = new_sboxw;
            end
            2'd2: begin
                sboxw               = block_q[63:32];
                sbox_state[63:32]   = new_sboxw;
            end
            2'd3: begin
                sboxw               = block_q[31:0];
                sbox_state[31:0]    = new_sboxw;
            end
        endcase
        shifted    = shift_rows(block_q);
        main_state = (last_round ? shifted : mix_columns(shifted)) ^ round_key;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            block_q     <= '0;
            round_ctr_q <= '0;
            word_ctr_q  <= '0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (next) begin
                        block_q     <= block ^ round_key;
                        keylen_q    <= keylen;
                        round_ctr_q <= 4'd1;
                        word_ctr_q  <= 2'd0;
                        ready_q     <= 1'b0;
                        state_q     <= StSbox;
                    end
                end
                StSbox: begin
                    block_q    <= sbox_state;
                    word_ctr_q <= word_ctr_q + 2'd1;
                    if (word_ctr_q == 2'd3) begin
                        state_q <= StMain;
                    end
                end
                StMain: begin
                    block_q <= main_state;
                    if (last_round) begin
                        // Counter returns to 0 so round reads 0 while idle.
                        round_ctr_q <= 4'd0;
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        round_ctr_q <= round_ctr_q + 4'd1;
                        state_q     <= StSbox;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign round     = round_ctr_q;
    assign new_block = block_q;
    assign ready     = ready_q;

endmodule
